// File: rtl/hazard_pkg.sv
// Shared types and stall-length constants for the ID-stage hazard unit.
package hazard_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_e;

  localparam int unsigned LEN_W = 2;

  localparam logic [LEN_W-1:0] STALL_LOAD_USE    = LEN_W'(1);
  localparam logic [LEN_W-1:0] STALL_BR_ALU      = LEN_W'(1);
  localparam logic [LEN_W-1:0] STALL_BR_LOAD_EX  = LEN_W'(2);
  localparam logic [LEN_W-1:0] STALL_BR_LOAD_MEM = LEN_W'(1);

  function automatic logic [LEN_W-1:0] len_max(input logic [LEN_W-1:0] a,
                                               input logic [LEN_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {Width{1'b1}})) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_unit.sv
// ID-stage hazard control: load-use / branch-operand stalls, taken-branch
// flush of IF/ID, and saturating stall/flush performance counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned AddressSize = 5,
  parameter int unsigned CountWidth  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AddressSize-1:0] IDRs1,
  input  logic [AddressSize-1:0] IDRs2,
  input  logic                   IDUsesRs1,
  input  logic                   IDUsesRs2,
  input  logic                   IDIsBranch,
  input  logic                   branchTaken,
  input  logic [AddressSize-1:0] EXRegisterRd,
  input  logic                   EXRegWrite,
  input  logic                   EXMemRead,
  input  logic [AddressSize-1:0] MemRegisterRd,
  input  logic                   MemMemRead,
  input  logic                   memStall,
  input  logic                   counterClear,
  output logic                   PCWrite,
  output logic                   IFIDWrite,
  output logic                   IDEXBubble,
  output logic                   IFIDFlush,
  output logic [CountWidth-1:0]  stallCycles,
  output logic [CountWidth-1:0]  flushCount
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] remain_q, remain_d;
  logic [LEN_W-1:0] len_c;
  logic             stall_c;
  logic             m_ex, m_mem;

  // Register x0 is hard-wired zero, so a zero destination is never a producer.
  assign m_ex  = (EXRegisterRd != '0) &&
                 (((EXRegisterRd == IDRs1) && IDUsesRs1) ||
                  ((EXRegisterRd == IDRs2) && IDUsesRs2));
  assign m_mem = (MemRegisterRd != '0) &&
                 (((MemRegisterRd == IDRs1) && IDUsesRs1) ||
                  ((MemRegisterRd == IDRs2) && IDUsesRs2));

  always_comb begin
    len_c = '0;
    if (EXMemRead && m_ex)
      len_c = len_max(len_c, STALL_LOAD_USE);
    if (IDIsBranch && EXRegWrite && !EXMemRead && m_ex)
      len_c = len_max(len_c, STALL_BR_ALU);
    if (IDIsBranch && EXMemRead && m_ex)
      len_c = len_max(len_c, STALL_BR_LOAD_EX);
    if (IDIsBranch && MemMemRead && m_mem)
      len_c = len_max(len_c, STALL_BR_LOAD_MEM);
  end

  // Next-state and stall decode; memStall freezes state and remain.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    stall_c  = 1'b0;
    case (state_q)
      IDLE: begin
        stall_c = (len_c != '0);
        if (!memStall && (len_c > LEN_W'(1))) begin
          state_d  = STALL;
          remain_d = len_c - LEN_W'(1);
        end
      end
      STALL: begin
        stall_c = 1'b1;
        if (!memStall) begin
          remain_d = remain_q - LEN_W'(1);
          if (remain_q <= LEN_W'(1)) state_d = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        remain_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
    end
  end

  assign PCWrite    = !stall_c && !memStall;
  assign IFIDWrite  = !stall_c && !memStall;
  assign IDEXBubble = stall_c && !memStall;
  // An operand still in flight means the compare is unresolved: no flush.
  assign IFIDFlush  = branchTaken && IDIsBranch && !stall_c && !memStall;

  sat_counter #(.Width(CountWidth)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (counterClear),
    .inc   (IDEXBubble),
    .count (stallCycles)
  );

  sat_counter #(.Width(CountWidth)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (counterClear),
    .inc   (IFIDFlush),
    .count (flushCount)
  );

endmodule
